// File: rtl/adder_accum.sv
// adder_accum: multi-word accumulator wrapped around an external combinational
// `width`-bit adder. A burst of `len` unsigned words is accepted over a
// valid/ready stream; each word is summed with the running low accumulator by
// the external adder, and the adder's carry is folded into an upper count. The
// full-width total is then held on a valid/ready output until it is taken.
//
// Ports:
//   clk, rst       clock (rising edge) and asynchronous active-low reset
//   en             global enable; low freezes all state and drops in_ready
//   start, len     burst request and word count (sampled only when idle)
//   in_valid/in_ready/in_data   input word stream
//   add_a, add_b   operands to the external adder (in_data, low accumulator)
//   add_sum        adder result, width+1 bits including carry
//   out_valid/out_ready/out_sum result stream, out_sum = {acc_hi, acc_lo}
//   busy           high whenever a burst is in progress or a result is held
module adder_accum #(
  parameter int unsigned width = 16,
  parameter int unsigned len_w = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   start,
  input  logic [len_w-1:0]       len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [width-1:0]       in_data,
  output logic [width-1:0]       add_a,
  output logic [width-1:0]       add_b,
  input  logic [width:0]         add_sum,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [width+len_w-1:0] out_sum,
  output logic                   busy
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e           state_q, state_d;
  logic [width-1:0] acc_lo_q, acc_lo_d;
  logic [len_w-1:0] acc_hi_q, acc_hi_d;
  logic [len_w-1:0] remaining_q, remaining_d;
  logic             accept;

  assign add_a     = in_data;
  assign add_b     = acc_lo_q;
  assign in_ready  = en && (state_q == StAccum);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_sum   = {acc_hi_q, acc_lo_q};

  always_comb begin
    state_d     = state_q;
    acc_lo_d    = acc_lo_q;
    acc_hi_d    = acc_hi_q;
    remaining_d = remaining_q;
    unique case (state_q)
      StIdle: begin
        if (start && en) begin
          acc_lo_d    = '0;
          acc_hi_d    = '0;
          remaining_d = len;
          state_d     = (len == '0) ? StDone : StAccum;
        end
      end
      StAccum: begin
        if (accept) begin
          acc_lo_d    = add_sum[width-1:0];
          // Carry out of the low word counts up in the high field; cannot wrap
          // because the burst length is bounded by the same field width.
          acc_hi_d    = acc_hi_q + len_w'(add_sum[width]);
          remaining_d = remaining_q - len_w'(1);
          if (remaining_q == len_w'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (out_ready && en) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      acc_lo_q    <= '0;
      acc_hi_q    <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_lo_q    <= acc_lo_d;
      acc_hi_q    <= acc_hi_d;
      remaining_q <= remaining_d;
    end
  end

endmodule

// File: tb/tb_adder_accum.sv
// Self-checking bench for adder_accum. The external adder is modelled by a
// continuous assign; expected totals are the plain arithmetic sum of the words
// the bench observes being accepted.
module tb_adder_accum;
  localparam int W  = 16;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          start;
  logic [LW-1:0] len;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [W-1:0]  add_a;
  logic [W-1:0]  add_b;
  logic [W:0]    add_sum;
  logic          out_valid;
  logic          out_ready;
  logic [W+LW-1:0] out_sum;
  logic          busy;

  int checks = 0;
  int errors = 0;

  adder_accum #(.width(W), .len_w(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .busy      (busy)
  );

  // The downstream 16-bit adder stage.
  assign add_sum = {1'b0, add_a} + {1'b0, add_b};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] word_for(input int mode, input int idx);
    case (mode)
      1:       return 16'hFFFF;
      2:       return W'(idx + 1);
      3:       return (idx == 0) ? 16'd5 : 16'd7;
      default: return W'($urandom);
    endcase
  endfunction

  // Runs one burst of n words, then exercises the held result and handshake.
  task automatic run_burst(input int n, input int mode, input bit gaps, input bit stall,
                           input int hold, input logic [W+LW-1:0] fixed_exp, input bit use_fixed);
    logic [W+LW-1:0] exp_sum;
    logic [W+LW-1:0] snap;
    int acc;
    int cyc;
    bit stalled;
    exp_sum = '0;
    acc     = 0;
    cyc     = 0;
    stalled = 1'b0;
    start = 1'b1;
    len   = LW'(n);
    step();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    while (acc < n && cyc < 4000) begin
      if (stall && !stalled && acc == n / 2) begin
        stalled  = 1'b1;
        en       = 1'b0;
        in_valid = 1'b1;
        in_data  = word_for(mode, acc);
        snap     = out_sum;
        repeat (3) begin
          #1;
          check("in_ready_en_low", in_ready, 0);
          step();
          check("frozen_sum", out_sum, snap);
          check("frozen_busy", busy, 1);
        end
        en = 1'b1;
      end
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = word_for(mode, acc);
      #1;
      check("in_ready_accum", in_ready, 1);
      check("add_a_follows", add_a, in_data);
      step();
      cyc++;
      if (in_valid) begin
        exp_sum += in_data;
        acc++;
      end
      check("out_valid_timing", out_valid, (acc == n));
    end
    in_valid = 1'b0;
    if (acc < n) check("burst_timeout", acc, n);
    if (!gaps && !stall) check("latency", cyc, n);
    if (use_fixed) check("model_vs_fixed", exp_sum, fixed_exp);
    check("out_valid_done", out_valid, 1);
    check("out_sum", out_sum, exp_sum);
    check("in_ready_done", in_ready, 0);
    repeat (hold) begin
      out_ready = 1'b0;
      start     = 1'($urandom_range(0, 1));
      step();
      check("hold_sum", out_sum, exp_sum);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    start     = 1'b0;
    en        = 1'b0;
    out_ready = 1'b1;
    step();
    check("no_handshake_en_low", out_valid, 1);
    en    = 1'b1;
    start = 1'b1;
    step();
    start     = 1'b0;
    out_ready = 1'b0;
    check("handshake_valid", out_valid, 0);
    check("start_ignored_busy", busy, 0);
    check("idle_keeps_sum", out_sum, exp_sum);
  endtask

  initial begin
    rst       = 1'b0;
    en        = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = 16'h1234;
    out_ready = 1'b0;
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_busy", busy, 0);
    check("rst_add_b", add_b, 0);
    check("rst_add_a", add_a, 16'h1234);
    @(negedge clk);
    rst = 1'b1;
    step();

    run_burst(3, 2, 1'b0, 1'b0, 0, 24'h000006, 1'b1);
    run_burst(4, 1, 1'b0, 1'b0, 0, 24'h03FFFC, 1'b1);
    run_burst(255, 1, 1'b0, 1'b0, 0, 24'hFEFF01, 1'b1);
    run_burst(0, 0, 1'b0, 1'b0, 2, 24'h000000, 1'b1);
    run_burst(6, 0, 1'b0, 1'b0, 5, '0, 1'b0);
    run_burst(10, 0, 1'b1, 1'b0, 1, '0, 1'b0);
    run_burst(8, 0, 1'b0, 1'b1, 0, '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_burst($urandom_range(1, 40), 0, 1'(i % 2), 1'(i / 2), $urandom_range(0, 3), '0, 1'b0);
    end

    // Reset pulse mid-burst.
    start = 1'b1;
    len   = LW'(5);
    step();
    start    = 1'b0;
    in_valid = 1'b1;
    repeat (2) begin
      in_data = W'($urandom);
      step();
    end
    rst = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_sum", out_sum, 0);
    check("midrst_busy", busy, 0);
    check("midrst_add_b", add_b, 0);
    in_data = 16'hBEEF;
    #1;
    check("midrst_add_a", add_a, 16'hBEEF);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();
    check("post_rst_idle", busy, 0);
    run_burst(2, 3, 1'b0, 1'b0, 0, 24'h00000C, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_accum.md
# adder_accum

Multi-word accumulator that sits directly upstream of the 16-bit `adder` stage and also consumes its output. It accepts a burst of `len` unsigned words over a valid/ready stream and drives each word plus the running low sum into the adder. It registers the adder's 17-bit result, folding the carry into an upper count, and presents the full-width total on a held valid/ready output.

## Interface
- `width`, default 16: data word width; must match the adder's `width`.
- `len_w`, default 8: burst-length field width; max burst is 2^len_w − 1 words.

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `en` in 1: global enable; low freezes all state and deasserts `in_ready`.
- `start` in 1: burst request; sampled only in IDLE.
- `len` in len_w: word count for the burst, captured with `start`.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: block accepts a word this cycle.
- `in_data` in width: operand word, unsigned.
- `add_a` out width: to adder `a`; combinationally equals `in_data`.
- `add_b` out width: to adder `b`; registered low accumulator `acc_lo`.
- `add_sum` in width+1: from adder `out`, combinational `add_a + add_b`.
- `out_valid` out 1: `out_sum` is valid.
- `out_ready` in 1: consumer takes the result.
- `out_sum` out width+len_w: `{acc_hi, acc_lo}`.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- **States:** IDLE, ACCUM, DONE.
- **IDLE:**
  - On `start && en`, clear `acc_lo` and `acc_hi`, and load `remaining <= len`.
  - If `len == 0`, go to DONE with sum 0; otherwise go to ACCUM.
  - `start` in ACCUM or DONE is ignored.
- **ACCUM:**
  - `in_ready = en`.
  - A word is accepted on `in_valid && in_ready`.
  - On accept: `acc_lo <= add_sum[width-1:0]`, `acc_hi <= acc_hi + add_sum[width]`, `remaining <= remaining − 1`.
  - When the accept consumes the last word (`remaining == 1`), go to DONE.
  - No accept means no state change.
- **DONE:**
  - `out_valid = 1`, and `out_sum` is held stable.
  - On `out_ready && en`, go to IDLE and drop `out_valid`.
  - `out_sum` keeps its value in IDLE until the next `start` clears it.
- **Arithmetic:** all operands are unsigned, and overflow is impossible. The largest total is (2^len_w − 1)·(2^width − 1), which is below 2^(width+len_w). `acc_hi` is len_w bits.
- **Enable:** `en` low blocks every transition and register update. Combinational `add_a` still follows `in_data`.
- **Reset (`rst` low, any time, including mid-burst):**
  - State goes to IDLE immediately.
  - `acc_lo`, `acc_hi` and `remaining` go to 0, and the partial sum is discarded.
  - Outputs during reset: `in_ready` 0, `out_valid` 0, `out_sum` 0, `busy` 0, `add_b` 0, `add_a` = `in_data`.

## Timing
- The adder path is combinational within the cycle: `in_data` → `add_a` → `add_sum` → `acc_*` registers. One word per cycle at full rate.
- **Latency:** with `start` sampled at edge 0 and `in_valid` held high:
  - words are accepted at edges 1..len;
  - `out_valid` rises after edge len, and stays high until `out_ready` is sampled.
- **len = 0:** `out_valid` is high the cycle after the `start` edge.
- **Minimum back-to-back spacing:** a new `start` is sampled no earlier than the cycle after the `out_ready` handshake, since `start` is only seen in IDLE.
- **Stream rules:** `in_ready` never depends on `in_valid`. A stalled `in_valid` simply extends ACCUM with no timeout.
- **Simultaneous events:**
  - `out_ready` together with `start` in DONE: the handshake completes and `start` is ignored.
  - `en` low together with `out_ready` high: no handshake.

## Test plan
- Reset, then `start`, `len=3`, words 1, 2, 3 on consecutive cycles → `in_ready` high for 3 cycles, `out_sum=0x000006`, `out_valid` after edge 3, `busy` high from edge 0 until the handshake.
- Carry chain: `len=4`, four words 0xFFFF → `out_sum=0x03FFFC` (`acc_hi=3`, `acc_lo=0xFFFC`).
- Maximum burst: `len=255`, all words 0xFFFF → `out_sum=0xFEFF01`, with no overflow.
- `len=0` → `out_valid` the next cycle, `out_sum=0`, and `in_ready` never asserted.
- Backpressure and ignore rules:
  - `out_ready` held low for 5 cycles in DONE → `out_sum` stable, `start` pulses ignored, `in_ready=0`;
  - `in_valid` gapped mid-burst → result unchanged.
- Enable and reset mid-burst:
  - `en` low for 3 cycles mid-burst → state frozen, final sum correct;
  - `rst` pulsed low mid-burst → outputs 0 immediately, and the next burst `len=2` with words 5, 7 yields 0x00000C.
